modsq_iter_ctrl: RTL and testbench

Single-clock, parametrised successor to the modular-squaring IO wrapper. It splits a MOD_LEN-bit input into redundant polynomial coefficients and pipes them to the squaring core through IN_STAGES registers. It launches the core, counts a programmable number of squaring iterations, and halts the core after the last one. The final coefficients are returned through OUT_STAGES registers with a single valid pulse. It sits between the host/AXI shell and `modular_square_8_cycles`; abort and busy status are added.

---
 rtl/modsq_pkg.sv | 24 ++
 rtl/modsq_pipe.sv | 41 ++++
 rtl/modsq_iter_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_modsq_iter_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modsq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modsq_pkg
//  Description : Shared coefficient widths, coefficient type and controller
//                state encoding for the modular-squaring iteration controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package modsq_pkg;

    localparam int DEF_WORD_LEN = 16;
    localparam int DEF_BIT_LEN  = 17;

    typedef logic [DEF_BIT_LEN-1:0] coef_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/modsq_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : modsq_pipe
//  Description : Reset-cleared delay line. Stage 0 only takes new data when
//                load_i is high, later stages shift every cycle, so the tail
//                settles to the loaded word and then holds it.
//  Revision    : 1.0 - initial release
// ============================================================================
module modsq_pipe
    import modsq_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Capture into stage 0 on load, shift the remaining stages every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            if (load_i) begin
                stage_q[0] <= d_i;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/modsq_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : modsq_iter_ctrl
//  Description : Splits the input into core coefficients, launches the
//                squaring core, counts iterations, halts the core after the
//                last one and returns the result through an output pipe with
//                a single valid strobe. Supports abort and reports busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module modsq_iter_ctrl
    import modsq_pkg::*;
#(
    parameter int MOD_LEN               = 1024,
    parameter int WORD_LEN              = DEF_WORD_LEN,
    parameter int BIT_LEN               = DEF_BIT_LEN,
    parameter int REDUNDANT_ELEMENTS    = 2,
    parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
    parameter int IN_STAGES             = 3,
    parameter int OUT_STAGES            = 3,
    parameter int ITER_W                = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  logic [ITER_W-1:0]                   iter_count_i,
    input  logic [MOD_LEN-1:0]                  sq_in_i,
    input  logic                                abort_i,
    output logic                                busy_o,
    output logic [ITER_W-1:0]                   iter_done_o,
    output logic [NUM_ELEMENTS*2*WORD_LEN-1:0]  sq_out_o,
    output logic                                valid_o,
    output logic                                core_start_o,
    output logic                                core_stop_o,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0]     core_sq_in_o,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0]     core_sq_out_i,
    input  logic                                core_valid_i
);

    // Last count value before leaving LOAD / DRAIN (each lasts STAGES-1 cycles).
    localparam logic [3:0] LOAD_LAST  = 4'(IN_STAGES - 2);
    localparam logic [3:0] DRAIN_LAST = 4'(OUT_STAGES - 2);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ITER_W-1:0]   target_q, target_d;
    logic [ITER_W-1:0]   iter_done_q, iter_done_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                core_start_q, core_start_d;
    logic                core_stop_q, core_stop_d;

    logic                w_in_load;
    logic                w_out_load;
    logic [ITER_W-1:0]   w_iter_inc;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] w_coef_in;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] w_coef_out;

    // Data coefficients carry one zero pad bit; redundant coefficients are zero.
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_coef
        if (j < NONREDUNDANT_ELEMENTS) begin : g_data
            assign w_coef_in[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(sq_in_i[j*WORD_LEN +: WORD_LEN]);
        end else begin : g_redundant
            assign w_coef_in[j*BIT_LEN +: BIT_LEN] = '0;
        end
        assign sq_out_o[j*2*WORD_LEN +: 2*WORD_LEN] = (2*WORD_LEN)'(w_coef_out[j*BIT_LEN +: BIT_LEN]);
    end

    modsq_pipe #(
        .WIDTH (NUM_ELEMENTS*BIT_LEN),
        .DEPTH (IN_STAGES)
    ) u_in_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_in_load),
        .d_i    (w_coef_in),
        .q_o    (core_sq_in_o)
    );

    modsq_pipe #(
        .WIDTH (NUM_ELEMENTS*BIT_LEN),
        .DEPTH (OUT_STAGES)
    ) u_out_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_out_load),
        .d_i    (core_sq_out_i),
        .q_o    (w_coef_out)
    );

    // The iteration count sticks at all-ones instead of wrapping.
    assign w_iter_inc = (iter_done_q == '1) ? iter_done_q : iter_done_q + ITER_W'(1);

    // Next-state and strobe decode; abort wins over a coincident final core_valid.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        iter_done_d = iter_done_q;
        w_in_load   = 1'b0;
        w_out_load  = 1'b0;
        core_stop_d = 1'b0;
        valid_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    w_in_load   = 1'b1;
                    target_d    = (iter_count_i == '0) ? ITER_W'(1) : iter_count_i;
                    iter_done_d = '0;
                    cnt_d       = '0;
                    state_d     = (IN_STAGES == 1) ? LAUNCH : LOAD;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    core_stop_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == LOAD_LAST) begin
                    state_d = LAUNCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            LAUNCH: begin
                if (abort_i) begin
                    core_stop_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    core_stop_d = 1'b1;
                    state_d     = IDLE;
                end else if (core_valid_i) begin
                    iter_done_d = w_iter_inc;
                    if (w_iter_inc == target_q) begin
                        w_out_load  = 1'b1;
                        core_stop_d = 1'b1;
                        cnt_d       = '0;
                        if (OUT_STAGES == 1) begin
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        core_start_d = (state_d == LAUNCH);
        busy_d       = (state_d != IDLE);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            target_q     <= '0;
            iter_done_q  <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            core_start_q <= 1'b0;
            core_stop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            iter_done_q  <= iter_done_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            core_start_q <= core_start_d;
            core_stop_q  <= core_stop_d;
        end
    end

    assign busy_o       = busy_q;
    assign valid_o      = valid_q;
    assign core_start_o = core_start_q;
    assign core_stop_o  = core_stop_q;
    assign iter_done_o  = iter_done_q;

endmodule
`default_nettype wire

// File: tb/tb_modsq_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modsq_iter_ctrl
//  Description : Self-checking bench for modsq_iter_ctrl with a behavioural
//                squaring core (x^2 mod 2^1024-189, one result per 8 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modsq_iter_ctrl;

    localparam int MOD_LEN = 1024;
    localparam int BIT_LEN = 17;
    localparam int NUM     = 66;
    localparam int NONRED  = 64;
    localparam int IN_ST   = 3;
    localparam int OUT_ST  = 3;
    localparam int ITER_W  = 32;
    localparam logic [2047:0] NMOD = (2048'd1 << 1024) - 2048'd189;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start_i;
    logic [ITER_W-1:0]        iter_count_i;
    logic [MOD_LEN-1:0]       sq_in_i;
    logic                     abort_i;
    logic                     busy_o;
    logic [ITER_W-1:0]        iter_done_o;
    logic [NUM*32-1:0]        sq_out_o;
    logic                     valid_o;
    logic                     core_start_o;
    logic                     core_stop_o;
    logic [NUM*BIT_LEN-1:0]   core_sq_in_o;
    logic [NUM*BIT_LEN-1:0]   core_sq_out;
    logic                     core_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    modsq_iter_ctrl #(
        .MOD_LEN    (MOD_LEN),
        .IN_STAGES  (IN_ST),
        .OUT_STAGES (OUT_ST),
        .ITER_W     (ITER_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start_i),
        .iter_count_i  (iter_count_i),
        .sq_in_i       (sq_in_i),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .iter_done_o   (iter_done_o),
        .sq_out_o      (sq_out_o),
        .valid_o       (valid_o),
        .core_start_o  (core_start_o),
        .core_stop_o   (core_stop_o),
        .core_sq_in_o  (core_sq_in_o),
        .core_sq_out_i (core_sq_out),
        .core_valid_i  (core_valid)
    );

    // ---------------- arithmetic helpers ----------------
    function automatic logic [1023:0] sqmod(input logic [1023:0] x);
        logic [2047:0] p;
        p = {1024'd0, x} * {1024'd0, x};
        p = p % NMOD;
        return p[1023:0];
    endfunction

    // Reference: the result is sq_in squared max(n,1) times modulo N.
    function automatic logic [1023:0] model(input logic [1023:0] v, input logic [31:0] t);
        logic [1023:0] x;
        x = v;
        for (int i = 0; i < int'(t); i++) x = sqmod(x);
        return x;
    endfunction

    function automatic logic [1023:0] from_coefs(input logic [NUM*BIT_LEN-1:0] c);
        logic [2047:0] acc;
        acc = '0;
        for (int j = 0; j < NUM; j++)
            acc = acc + ({2031'd0, c[j*BIT_LEN +: BIT_LEN]} << (16*j));
        acc = acc % NMOD;
        return acc[1023:0];
    endfunction

    function automatic logic [NUM*BIT_LEN-1:0] to_coefs(input logic [1023:0] x);
        logic [NUM*BIT_LEN-1:0] c;
        c = '0;
        for (int j = 0; j < NONRED; j++) c[j*BIT_LEN +: BIT_LEN] = {1'b0, x[j*16 +: 16]};
        return c;
    endfunction

    // ---------------- behavioural squaring core ----------------
    logic          st_act;
    logic [2:0]    st_cnt;
    logic [1023:0] st_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_act      <= 1'b0;
            st_cnt      <= '0;
            st_val      <= '0;
            core_valid  <= 1'b0;
            core_sq_out <= '0;
        end else if (core_stop_o) begin
            st_act     <= 1'b0;
            core_valid <= 1'b0;
        end else if (core_start_o) begin
            st_act     <= 1'b1;
            st_cnt     <= '0;
            st_val     <= from_coefs(core_sq_in_o);
            core_valid <= 1'b0;
        end else if (st_act) begin
            if (st_cnt == 3'd7) begin
                st_cnt      <= '0;
                st_val      <= sqmod(st_val);
                core_sq_out <= to_coefs(sqmod(st_val));
                core_valid  <= 1'b1;
            end else begin
                st_cnt     <= st_cnt + 3'd1;
                core_valid <= 1'b0;
            end
        end else begin
            core_valid <= 1'b0;
        end
    end

    // ---------------- event monitor (sampled 1 unit after each edge) ----------------
    int edge_n = 0, n_valid = 0, n_stop = 0;
    int valid_edge = -1, stop_edge = -1, cs_edge = -1, cv_edge = -1;

    always @(posedge clk) begin
        #1;
        edge_n++;
        if (valid_o)      begin n_valid++; valid_edge = edge_n; end
        if (core_stop_o)  begin n_stop++;  stop_edge  = edge_n; end
        if (core_start_o) cs_edge = edge_n;
        if (core_valid)   cv_edge = edge_n + 1;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_sq(input string tag, input logic [1023:0] expv);
        for (int j = 0; j < NUM; j++) begin
            logic [63:0] e;
            if (j < NONRED) e = 64'(expv[j*16 +: 16]);
            else            e = 64'd0;
            chk($sformatf("%s[%0d]", tag, j), 64'(sq_out_o[j*32 +: 32]), e);
        end
    endtask

    logic [1023:0] last_exp = '0;

    // mode 0: plain run; 1: abort with the abort_k-th core_valid; 2: abort during DRAIN.
    task automatic run(input logic [1023:0] v, input logic [31:0] n, input int mode,
                       input int abort_k, input bit poke);
        int v0, s0, k, t, my_s, a_edge;
        bit pend;
        logic [31:0] tgt;
        logic [1023:0] expv;
        tgt  = (n == 0) ? 32'd1 : n;
        expv = model(v, tgt);
        v0 = n_valid; s0 = n_stop; k = 0; t = 0; pend = 0; a_edge = -1;
        @(negedge clk);
        chk("valid_idle", {63'd0, valid_o}, 64'd0);
        start_i = 1'b1; iter_count_i = n; sq_in_i = v; my_s = edge_n + 1;
        @(negedge clk);
        start_i = 1'b0; iter_count_i = $urandom; sq_in_i = ~v;
        while (busy_o && t < 1000) begin
            abort_i = 1'b0;
            start_i = 1'b0;
            if (poke && t == 6) begin start_i = 1'b1; iter_count_i = 32'd1; end
            if (pend) begin abort_i = 1'b1; pend = 0; end
            if (core_valid) begin
                k++;
                if (mode == 1 && k == abort_k) begin abort_i = 1'b1; a_edge = edge_n + 1; end
                if (mode == 2 && k == int'(tgt)) pend = 1;
            end
            @(negedge clk);
            t++;
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("run_timeout", {63'd0, busy_o}, 64'd0);
        if (mode == 1) begin
            chk("abort_stop_cnt", 64'(n_stop - s0), 64'd1);
            chk("abort_stop_cyc", 64'(stop_edge), 64'(a_edge));
            chk("abort_iter_done", 64'(iter_done_o), 64'(abort_k - 1));
            repeat (12) @(negedge clk);
            chk("abort_no_valid", 64'(n_valid - v0), 64'd0);
            chk("abort_busy", {63'd0, busy_o}, 64'd0);
            chk_sq("abort_sq_kept", last_exp);
        end else begin
            chk("valid_now", {63'd0, valid_o}, 64'd1);
            chk("valid_cnt", 64'(n_valid - v0), 64'd1);
            chk("stop_cnt", 64'(n_stop - s0), 64'd1);
            chk("start_cyc", 64'(cs_edge - my_s), 64'(IN_ST - 1));
            chk("valid_lat", 64'(valid_edge - cv_edge), 64'(OUT_ST - 1));
            chk("stop_cyc", 64'(stop_edge), 64'(cv_edge));
            chk("iter_done", 64'(iter_done_o), 64'(tgt));
            chk_sq("sq_out", expv);
            last_exp = expv;
        end
    endtask

    // Hard stop in case the whole sequence stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int v_before;
        logic [1023:0] rv;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; iter_count_i = '0; sq_in_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_core_start", {63'd0, core_start_o}, 64'd0);
        chk("rst_core_stop", {63'd0, core_stop_o}, 64'd0);
        chk("rst_iter_done", 64'(iter_done_o), 64'd0);
        chk("rst_core_sq_in", core_sq_in_o[63:0], 64'd0);
        chk_sq("rst_sq_out", '0);
        rst_n = 1'b1;
        @(negedge clk);

        run(1024'd3, 32'd1, 0, 0, 1'b0);
        chk("sq3_coef0", 64'(sq_out_o[31:0]), 64'd9);
        run(1024'd2, 32'd5, 0, 0, 1'b0);
        chk("sq2_coef2", 64'(sq_out_o[95:64]), 64'd1);
        run(1024'd7, 32'd0, 0, 0, 1'b0);
        chk("sq7_coef0", 64'(sq_out_o[31:0]), 64'd49);
        run(1024'd13, 32'd3, 1, 3, 1'b0);
        run(1024'd6, 32'd2, 2, 0, 1'b0);

        v_before = n_valid;
        run(1024'd5, 32'd2, 0, 0, 1'b1);
        run(1024'd9, 32'd1, 0, 0, 1'b0);
        chk("b2b_results", 64'(n_valid - v_before), 64'd2);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start_i = 1'b1; iter_count_i = 32'd4; sq_in_i = 1024'd11;
        @(negedge clk);
        start_i = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_mid_busy_pre", {63'd0, busy_o}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_busy", {63'd0, busy_o}, 64'd0);
        chk("rstm_valid", {63'd0, valid_o}, 64'd0);
        chk("rstm_core_start", {63'd0, core_start_o}, 64'd0);
        chk("rstm_core_stop", {63'd0, core_stop_o}, 64'd0);
        chk("rstm_iter_done", 64'(iter_done_o), 64'd0);
        chk("rstm_core_sq_in", core_sq_in_o[63:0], 64'd0);
        chk_sq("rstm_sq_out", '0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
        run(1024'd5, 32'd1, 0, 0, 1'b0);
        chk("sq5_coef0", 64'(sq_out_o[31:0]), 64'd25);

        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 32; w++) rv[w*32 +: 32] = $urandom;
            run(rv, 32'($urandom_range(0, 6)), 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
